// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// controller for the MEM stage. Hit gates the negedge pipeline registers.
// Optional macro DCACHE_STATS_EN adds Read_Count / Miss_Count outputs.
module dcache_ctrl #(
    parameter int unsigned INDEX_BITS  = 4,
    parameter int unsigned OFFSET_BITS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MEM_Read,
    input  logic        MEM_Write,
    input  logic [31:0] Address,
    input  logic [31:0] Write_Data,
    output logic [31:0] Read_Data,
    output logic        Hit,
    output logic        Mem_Req,
    output logic        Mem_We,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_Wdata,
    input  logic [31:0] Mem_Rdata,
    input  logic        Mem_Ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] Read_Count,
    output logic [31:0] Miss_Count
`endif
);

    localparam int unsigned LINES    = 1 << INDEX_BITS;
    localparam int unsigned WORDS    = 1 << OFFSET_BITS;
    localparam int unsigned IDX_LSB  = OFFSET_BITS + 2;
    localparam int unsigned TAG_LSB  = OFFSET_BITS + INDEX_BITS + 2;
    localparam int unsigned TAG_BITS = 32 - TAG_LSB;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_WDONE = 2'd3;

    logic [1:0]             r_state;
    logic [LINES-1:0]       r_valid;
    logic [TAG_BITS-1:0]    r_tag  [LINES];
    logic [31:0]            r_data [LINES][WORDS];
    logic [31:0]            r_addr;
    logic [31:0]            r_wdata;
    logic [OFFSET_BITS-1:0] r_cnt;

    logic [1:0]             w_next_state;
    logic                   w_miss;
    logic                   w_read_hit;
    logic                   w_fill_last;
    logic                   w_write_upd;

    logic [TAG_BITS-1:0]    w_in_tag;
    logic [INDEX_BITS-1:0]  w_in_idx;
    logic [OFFSET_BITS-1:0] w_in_word;
    logic                   w_in_hit;
    logic [TAG_BITS-1:0]    w_lat_tag;
    logic [INDEX_BITS-1:0]  w_lat_idx;
    logic [OFFSET_BITS-1:0] w_lat_word;
    logic                   w_lat_hit;
    logic                   w_unused;

    // Address decode for the live access and for the latched access
    assign w_in_tag   = Address[31:TAG_LSB];
    assign w_in_idx   = Address[TAG_LSB-1:IDX_LSB];
    assign w_in_word  = Address[IDX_LSB-1:2];
    assign w_in_hit   = r_valid[w_in_idx] && (r_tag[w_in_idx] == w_in_tag);
    assign w_lat_tag  = r_addr[31:TAG_LSB];
    assign w_lat_idx  = r_addr[TAG_LSB-1:IDX_LSB];
    assign w_lat_word = r_addr[IDX_LSB-1:2];
    assign w_lat_hit  = r_valid[w_lat_idx] && (r_tag[w_lat_idx] == w_lat_tag);
    assign w_unused   = ^{Address[1:0], r_addr[1:0]};

    // Next-state and output decode; reset forces the idle/no-stall view
    always_comb begin
        w_next_state = r_state;
        w_miss       = 1'b0;
        w_read_hit   = 1'b0;
        w_fill_last  = 1'b0;
        w_write_upd  = 1'b0;
        Hit          = 1'b1;
        Read_Data    = 32'd0;
        Mem_Req      = 1'b0;
        Mem_We       = 1'b0;
        Mem_Addr     = 32'd0;
        Mem_Wdata    = 32'd0;
        if (rst_n) begin
            case (r_state)
                S_IDLE: begin
                    if (MEM_Write) begin
                        Hit          = 1'b0;
                        w_next_state = S_WRITE;
                    end else if (MEM_Read) begin
                        if (w_in_hit) begin
                            w_read_hit = 1'b1;
                            Read_Data  = r_data[w_in_idx][w_in_word];
                        end else begin
                            Hit          = 1'b0;
                            w_miss       = 1'b1;
                            w_next_state = S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    Hit      = 1'b0;
                    Mem_Req  = 1'b1;
                    Mem_Addr = {r_addr[31:IDX_LSB], r_cnt, 2'b00};
                    if (Mem_Ack && (r_cnt == '1)) begin
                        w_fill_last  = 1'b1;
                        w_next_state = S_IDLE;
                    end
                end
                S_WRITE: begin
                    Hit       = 1'b0;
                    Mem_Req   = 1'b1;
                    Mem_We    = 1'b1;
                    Mem_Addr  = r_addr;
                    Mem_Wdata = r_wdata;
                    if (Mem_Ack) begin
                        w_write_upd  = w_lat_hit;
                        w_next_state = S_WDONE;
                    end
                end
                S_WDONE: begin
                    w_next_state = S_IDLE;
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    // State, valid bits, latched access and word counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_valid <= '0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == S_IDLE) && (MEM_Write || w_miss)) begin
                r_addr  <= {Address[31:2], 2'b00};
                r_wdata <= Write_Data;
                r_cnt   <= '0;
            end
            // The victim line is invalid for the whole fill
            if (w_miss) begin
                r_valid[w_in_idx] <= 1'b0;
            end
            if ((r_state == S_FILL) && Mem_Ack) begin
                r_cnt <= r_cnt + OFFSET_BITS'(1);
            end
            if (w_fill_last) begin
                r_valid[w_lat_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays; contents are qualified by r_valid so need no reset
    always_ff @(posedge clk) begin
        if ((r_state == S_FILL) && Mem_Ack) begin
            r_data[w_lat_idx][r_cnt] <= Mem_Rdata;
        end
        if (w_fill_last) begin
            r_tag[w_lat_idx] <= w_lat_tag;
        end
        if (w_write_upd) begin
            r_data[w_lat_idx][w_lat_word] <= r_wdata;
        end
    end

`ifdef DCACHE_STATS_EN
    // Access statistics; the read waiting on a fill retires on the negedge
    // right after the last ack, so it is counted on that ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Read_Count <= 32'd0;
            Miss_Count <= 32'd0;
        end else begin
            if (w_read_hit || w_fill_last) begin
                Read_Count <= Read_Count + 32'd1;
            end
            if (w_miss) begin
                Miss_Count <= Miss_Count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed scenarios followed by random loads/stores,
// checked against a line-presence model and a flat memory model.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MEM_Read, MEM_Write;
    logic [31:0] Address, Write_Data, Read_Data;
    logic        Hit, Mem_Req, Mem_We, Mem_Ack;
    logic [31:0] Mem_Addr, Mem_Wdata, Mem_Rdata;
`ifdef DCACHE_STATS_EN
    logic [31:0] Read_Count, Miss_Count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Backing memory (sparse) and which 16-byte line each of 16 slots holds
    logic [31:0] mem [logic [31:0]];
    int          ref_line [16];

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MEM_Read   (MEM_Read),
        .MEM_Write  (MEM_Write),
        .Address    (Address),
        .Write_Data (Write_Data),
        .Read_Data  (Read_Data),
        .Hit        (Hit),
        .Mem_Req    (Mem_Req),
        .Mem_We     (Mem_We),
        .Mem_Addr   (Mem_Addr),
        .Mem_Wdata  (Mem_Wdata),
        .Mem_Rdata  (Mem_Rdata),
        .Mem_Ack    (Mem_Ack)
`ifdef DCACHE_STATS_EN
        ,
        .Read_Count (Read_Count),
        .Miss_Count (Miss_Count)
`endif
    );

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (mem.exists(w)) return mem[w];
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit ref_hit(input logic [31:0] a);
        return ref_line[a[7:4]] == int'(a[31:4]);
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (Mem_Req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        if (!ok) chk("mem_req_timeout", 32'(Mem_Req), 32'd1);
    endtask

    // Memory answers after a random 0..2 cycle wait; returns at posedge+1
    task automatic ack_word(input logic [31:0] data);
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk); #1;
            chk("req_held", 32'(Mem_Req), 32'd1);
        end
        Mem_Rdata = data;
        Mem_Ack   = 1'b1;
        @(posedge clk); #1;
        Mem_Ack   = 1'b0;
        Mem_Rdata = $urandom;
    endtask

    task automatic check_reset_outputs();
        chk("rst_hit",    32'(Hit),     32'd1);
        chk("rst_rdata",  Read_Data,    32'd0);
        chk("rst_req",    32'(Mem_Req), 32'd0);
        chk("rst_we",     32'(Mem_We),  32'd0);
        chk("rst_addr",   Mem_Addr,     32'd0);
        chk("rst_wdata",  Mem_Wdata,    32'd0);
    endtask

    task automatic do_read(input logic [31:0] a);
        bit          ok;
        logic [31:0] base;
        @(negedge clk);
        MEM_Read = 1'b1; MEM_Write = 1'b0; Address = a;
        #1;
        if (ref_hit(a)) begin
            chk("rd_hit",   32'(Hit),     32'd1);
            chk("rd_data",  Read_Data,    mem_rd(a));
            chk("rd_noreq", 32'(Mem_Req), 32'd0);
        end else begin
            chk("miss_stall", 32'(Hit), 32'd0);
            chk("miss_rdata", Read_Data, 32'd0);
            base = {a[31:4], 4'h0};
            for (int w = 0; w < 4; w++) begin
                wait_req(ok);
                if (!ok) return;
                chk("fill_we",    32'(Mem_We), 32'd0);
                chk("fill_addr",  Mem_Addr,    base + 32'(4 * w));
                chk("fill_stall", 32'(Hit),    32'd0);
                ack_word(mem_rd(base + 32'(4 * w)));
            end
            ref_line[a[7:4]] = int'(a[31:4]);
            chk("fill_hit",    32'(Hit),     32'd1);
            chk("fill_data",   Read_Data,    mem_rd(a));
            chk("fill_req_off", 32'(Mem_Req), 32'd0);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit both);
        bit ok;
        @(negedge clk);
        MEM_Write = 1'b1; MEM_Read = both; Address = a; Write_Data = d;
        #1;
        chk("wr_stall", 32'(Hit), 32'd0);
        chk("wr_rdata", Read_Data, 32'd0);
        wait_req(ok);
        if (!ok) return;
        chk("wr_we",     32'(Mem_We), 32'd1);
        chk("wr_addr",   Mem_Addr,    {a[31:2], 2'b00});
        chk("wr_wdata",  Mem_Wdata,   d);
        chk("wr_stall2", 32'(Hit),    32'd0);
        ack_word($urandom);
        mem[{a[31:2], 2'b00}] = d;
        chk("wdone_hit",   32'(Hit),     32'd1);
        chk("wdone_req",   32'(Mem_Req), 32'd0);
        chk("wdone_rdata", Read_Data,    32'd0);
        @(negedge clk);
        MEM_Write = 1'b0; MEM_Read = 1'b0;
    endtask

    task automatic do_idle();
        @(negedge clk);
        MEM_Read = 1'b0; MEM_Write = 1'b0;
        #1;
        chk("idle_hit", 32'(Hit),     32'd1);
        chk("idle_req", 32'(Mem_Req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        logic [31:0] a;
        rst_n = 1'b0; MEM_Read = 1'b0; MEM_Write = 1'b0;
        Address = 32'd0; Write_Data = 32'd0; Mem_Ack = 1'b0; Mem_Rdata = 32'd0;
        foreach (ref_line[i]) ref_line[i] = -1;
        mem[32'h100] = 32'h11; mem[32'h104] = 32'h22;
        mem[32'h108] = 32'h33; mem[32'h10C] = 32'h44;
        #12;
        check_reset_outputs();
        @(negedge clk); rst_n = 1'b1;

        // Cold miss and refill, then a same-line hit
        do_read(32'h100);
        do_read(32'h104);
        do_idle();
`ifdef DCACHE_STATS_EN
        chk("read_count", Read_Count, 32'd2);
        chk("miss_count", Miss_Count, 32'd1);
`endif

        // Conflict on index 0
        do_read(32'h200);
        do_read(32'h100);

        // Store hit updates cache; store miss does not allocate
        do_write(32'h108, 32'hDEAD_BEEF, 1'b0);
        do_read(32'h108);
        do_write(32'h300, 32'hCAFE_0300, 1'b0);
        do_read(32'h300);
        do_read(32'h304);

        // Stray acknowledge while idle must not disturb anything
        @(negedge clk);
        Mem_Rdata = 32'hBAD0_BAD0; Mem_Ack = 1'b1;
        @(posedge clk); #1;
        Mem_Ack = 1'b0;
        chk("stray_ack_hit", 32'(Hit),     32'd1);
        chk("stray_ack_req", 32'(Mem_Req), 32'd0);
        do_read(32'h308);

        // Reset after two fill acks
        @(negedge clk);
        MEM_Read = 1'b1; Address = 32'h500;
        #1;
        chk("rstfill_stall", 32'(Hit), 32'd0);
        for (int w = 0; w < 2; w++) begin
            wait_req(ok);
            if (ok) ack_word(mem_rd(32'h500 + 32'(4 * w)));
        end
        chk("rstfill_req_before", 32'(Mem_Req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs();
        foreach (ref_line[i]) ref_line[i] = -1;
`ifdef DCACHE_STATS_EN
        chk("rst_read_count", Read_Count, 32'd0);
        chk("rst_miss_count", Miss_Count, 32'd0);
`endif
        @(negedge clk);
        MEM_Read = 1'b0; rst_n = 1'b1;
        do_read(32'h100);
        do_read(32'h500);
        do_read(32'h50C);

        // Random mix over a few tags and indices to get hits and conflicts
        for (int k = 0; k < 60; k++) begin
            a = (32'($urandom_range(1, 3)) << 8) | (32'($urandom_range(0, 3)) << 4)
              | (32'($urandom_range(0, 3)) << 2);
            if ($urandom_range(0, 9) < 3) do_write(a, $urandom, $urandom_range(0, 4) == 0);
            else                          do_read(a);
        end
        do_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
